// File: rtl/rr_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_dispatch : round-robin job dispatcher, rotate / arbitrate modes |
// | Optional accepted-job counter enabled by RR_DISPATCH_STATS_EN      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_dispatch #(
  parameter int NUM_WRK = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic                       shift_enable,
  input  logic [NUM_WRK-1:0]         req,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic                       ack,
  output logic [NUM_WRK-1:0]         grant,
  output logic                       grant_valid,
  output logic [$clog2(NUM_WRK)-1:0] grant_idx,
  output logic [NUM_WRK-1:0]         mask,
  output logic [CNT_W-1:0]           grant_cnt
);

  localparam int IDX_W = $clog2(NUM_WRK);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_WRK-1:0] grant_q, grant_d;
  logic [NUM_WRK-1:0] mask_q, mask_d;
  logic               grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  int                 scan;
  logic               accept;

  always_comb begin
    ptr = '0;
    for (int i = 0; i < NUM_WRK; i++) begin
      if (mask_q[i]) ptr = IDX_W'(i);
    end
  end

  // Scan from the farthest candidate back to the pointer so the nearest one wins.
  always_comb begin
    win_idx = '0;
    scan    = 0;
    cand    = '0;
    for (int k = NUM_WRK - 1; k >= 0; k--) begin
      scan = int'(ptr) + k;
      if (scan >= NUM_WRK) scan = scan - NUM_WRK;
      cand = IDX_W'(scan);
      if (req[cand]) win_idx = cand;
    end
  end

  assign job_ready = (state_q == IDLE) && mode && (|req);
  assign accept    = job_valid && job_ready;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    mask_d        = mask_q;
    case (state_q)
      IDLE: begin
        if (!mode) begin
          if (shift_enable) mask_d = {mask_q[NUM_WRK-2:0], mask_q[NUM_WRK-1]};
        end else if (accept) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          grant_idx_d      = win_idx;
          grant_valid_d    = 1'b1;
          state_d          = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          mask_d        = {grant_q[NUM_WRK-2:0], grant_q[NUM_WRK-1]};
          state_d       = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      mask_q        <= {{(NUM_WRK-1){1'b0}}, 1'b1};
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      mask_q        <= mask_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign mask        = mask_q;

`ifdef RR_DISPATCH_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating: holds at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`else
  assign grant_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: doc/rr_dispatch.md
# rr_dispatch

Parametrised round-robin job dispatcher for the Julia worker array; the next generation of the rotating one-hot mask generator. Legacy mode keeps the free-running rotating one-hot mask. Arbitrate mode adds request-aware grant selection that skips busy workers, a job-source handshake, and per-grant acknowledge from the worker. Sits between the job/pixel source and the `NUM_WRK` Julia workers.

## Interface
- `NUM_WRK`, 4: number of Julia workers, ≥2.
- `CNT_W`, 16: width of the grant statistics counter.

Ports:
- `clk`: in, 1. Single clock; all state updates on rising edge.
- `rst`: in, 1. Reset, asynchronous, active-high.
- `mode`: in, 1.
  - 0: rotate mode.
  - 1: arbitrate mode.
- `shift_enable`: in, 1. Rotate-mode advance.
- `req`: in, `NUM_WRK`. Bit i high means worker i is idle and can accept a job.
- `job_valid`: in, 1. Job source has a job.
- `job_ready`: out, 1. Combinational; job accepted this cycle when `job_valid && job_ready`.
- `ack`: in, 1. Granted worker has latched the job.
- `grant`: out, `NUM_WRK`. Registered one-hot grant; all zero when no grant is held.
- `grant_valid`: out, 1. Registered; high while a grant is held.
- `grant_idx`: out, `$clog2(NUM_WRK)`. Registered binary index of the `grant` bit.
- `mask`: out, `NUM_WRK`. Registered one-hot rotating priority pointer.
- `grant_cnt`: out, `CNT_W`. Accepted-job counter; see Configuration.

## Operation
Reset values:
- `mask` = 1 (bit 0).
- `grant` = 0, `grant_valid` = 0, `grant_idx` = 0, `grant_cnt` = 0.
- FSM = IDLE.

Pointer rotation:
- `mask` rotates left by one.
- Bit `NUM_WRK-1` wraps to bit 0.
- `mask` is always exactly one-hot.

FSM states are IDLE and GRANT.

IDLE, `mode`=0 (rotate):
- `job_ready` = 0.
- On `shift_enable`, `mask` rotates left one position.
- `req`, `job_valid` and `ack` are ignored.

IDLE, `mode`=1 (arbitrate):
- `job_ready` = `|req`.
- When `job_valid && |req`:
  - Select the first set `req` bit at or above the `mask` position, wrapping past `NUM_WRK-1` to 0.
  - Register it into `grant` and `grant_idx`.
  - Set `grant_valid`.
  - Go to GRANT.
- `shift_enable` is ignored.

GRANT:
- `job_ready` = 0.
- `grant` and `grant_idx` are held stable regardless of `req`, `job_valid`, `mode` or `shift_enable`.
- On `ack`:
  - Clear `grant` and `grant_valid`.
  - Load `mask` with `grant` rotated left by one (the worker after the winner now has top priority).
  - Go to IDLE.

Boundary conditions:
- `ack` in IDLE is ignored.
- Granted worker's `req` dropping during GRANT has no effect; only `ack` exits GRANT.
- `mode` is sampled only in IDLE. A mode change during GRANT takes effect after the `ack`.
- `job_valid` with `req` = 0: `job_ready` = 0 and no state change.
- Winner at bit `NUM_WRK-1`: `mask` wraps to 1 on `ack`.
- `rst` asserted in any state, including mid-GRANT: immediate return to reset values; a pending grant is dropped.

## Timing
- Job acceptance at cycle N (`job_valid && job_ready`): `grant`, `grant_idx` and `grant_valid` are valid at N+1.
- `ack` sampled at cycle M: `grant_valid` = 0 and the new `mask` are visible at M+1.
- Earliest next acceptance is cycle M+1, so the minimum grant-to-grant spacing is 2 cycles.
- Rotate mode: `shift_enable` at cycle N gives the rotated `mask` at N+1, so one rotation per enabled cycle.
- `job_ready` is a combinational function of FSM state, `mode` and `req`. It has no path from `job_valid`.

## Configuration
- Macro: `RR_DISPATCH_STATS_EN`.
- Defined:
  - `grant_cnt` increments by one on each accepted job (`job_valid && job_ready`).
  - It saturates at all-ones and never wraps.
  - It is cleared only by `rst`.
- Undefined:
  - Counter logic is not built.
  - The `grant_cnt` port remains and is tied to 0, so instantiations are unchanged.

## Test plan
- Reset mid-GRANT: hold `mode`=1 with a grant outstanding, pulse `rst` -> `grant`=0, `grant_valid`=0, `mask`=0001 immediately; `job_ready`=1 at the first clock after release with `req`=1111.
- Rotate mode: `mode`=0, five `shift_enable` cycles -> `mask` = 0010, 0100, 1000, 0001, 0010; `job_ready` stays 0 and `grant_valid` stays 0.
- Fairness: `mode`=1, `req`=1111, `job_valid`=1, `ack` one cycle after each `grant_valid` -> `grant` sequence 0001, 0010, 0100, 1000, 0001; `grant_idx` sequence 0, 1, 2, 3, 0.
- Skip and wrap: `mask`=0010, `req`=1001, `job_valid`=1 -> `grant`=1000, `grant_idx`=3; after `ack`, `mask`=0001.
- Hold and ignore: during GRANT drop `req` to 0000, toggle `mode` and `shift_enable`, hold `ack`=0 for 10 cycles -> `grant` is unchanged and `job_ready` stays 0. Also: `job_valid`=1 with `req`=0000 in IDLE -> `job_ready`=0 and no grant.
- Stats, with `RR_DISPATCH_STATS_EN` defined and `CNT_W`=3: 10 accepted jobs -> `grant_cnt` = 1…7, then holds at 7. With the macro undefined -> `grant_cnt`=0 throughout.
